apu_mailbox: RTL

Bidirectional word mailbox between the host CPU and the APU, on the APU peripheral bus beside the softirq block. It holds two FIFOs, host-to-APU (H2A) and APU-to-host (A2H), behind one zero-wait AHB-Lite slave that both masters reach through the fabric. Its level interrupts go to the APU core's external IRQ input, next to `riscv_softirq`, and to the host interrupt controller. Software can then pass data and signal the other side without polling.

---
 rtl/apu_mailbox.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/apu_mailbox.sv
// ---------------------------------------------------------------------------
// apu_mailbox : host<->APU word mailbox (two FIFOs) behind a zero-wait AHB-Lite slave
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module apu_mailbox #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] ahbls_haddr,
   input  logic [1:0]  ahbls_htrans,
   input  logic        ahbls_hwrite,
   input  logic [2:0]  ahbls_hsize,
   input  logic        ahbls_hready,
   output logic        ahbls_hready_resp,
   input  logic [31:0] ahbls_hwdata,
   output logic [31:0] ahbls_hrdata,
   output logic        ahbls_hresp,
   output logic        host_irq,
   output logic        apu_irq
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [1:0] REG_FIFO = 2'd0;
   localparam logic [1:0] REG_STAT = 2'd1;

   typedef logic [AW:0] ptr_t;

   logic [31:0] h2a_mem [DEPTH];
   logic [31:0] a2h_mem [DEPTH];
   ptr_t        h2a_wp, h2a_rp, a2h_wp, a2h_rp;
   logic        host_unf, host_ovf, host_ien;
   logic        apu_unf, apu_ovf, apu_ien;

   logic        dp_valid, dp_view, dp_write;
   logic [1:0]  dp_reg;

   logic        h2a_empty, h2a_full, a2h_empty, a2h_full;
   ptr_t        h2a_lvl, a2h_lvl;
   logic        rx_empty, tx_full;
   logic [31:0] rx_head, stat_word;
   logic        fifo_acc, push, pop, ovf_evt, unf_evt, stat_wr;
   logic        h2a_push, h2a_pop, a2h_push, a2h_pop;
   logic        unused_bits;

   assign unused_bits = ^{ahbls_hsize, ahbls_haddr[15:9], ahbls_haddr[7:4],
                          ahbls_haddr[1:0], ahbls_htrans[0]};

   assign ahbls_hready_resp = 1'b1;
   assign ahbls_hresp       = 1'b0;

   // Wrap bit distinguishes full from empty when the index bits match
   assign h2a_empty = (h2a_wp == h2a_rp);
   assign a2h_empty = (a2h_wp == a2h_rp);
   assign h2a_full  = (h2a_wp[AW-1:0] == h2a_rp[AW-1:0]) && (h2a_wp[AW] != h2a_rp[AW]);
   assign a2h_full  = (a2h_wp[AW-1:0] == a2h_rp[AW-1:0]) && (a2h_wp[AW] != a2h_rp[AW]);
   assign h2a_lvl   = h2a_wp - h2a_rp;
   assign a2h_lvl   = a2h_wp - a2h_rp;

   assign host_irq = host_ien && !a2h_empty;
   assign apu_irq  = apu_ien && !h2a_empty;

   function automatic logic [31:0] pack_stat(input logic empty, input logic full,
                                             input ptr_t lvl, input logic unf,
                                             input logic ovf, input logic ien);
      logic [7:0] lvl8;
      lvl8 = 8'(lvl);
      return {15'b0, ien, 6'b0, ovf, unf, lvl8[3:0], 2'b0, !full, !empty};
   endfunction

   always_comb begin
      rx_empty  = 1'b1;
      tx_full   = 1'b0;
      rx_head   = '0;
      stat_word = '0;
      if (dp_view) begin
         rx_empty  = h2a_empty;
         tx_full   = a2h_full;
         rx_head   = h2a_mem[h2a_rp[AW-1:0]];
         stat_word = pack_stat(h2a_empty, a2h_full, h2a_lvl, apu_unf, apu_ovf, apu_ien);
      end else begin
         rx_empty  = a2h_empty;
         tx_full   = h2a_full;
         rx_head   = a2h_mem[a2h_rp[AW-1:0]];
         stat_word = pack_stat(a2h_empty, h2a_full, a2h_lvl, host_unf, host_ovf, host_ien);
      end
   end

   assign fifo_acc = dp_valid && (dp_reg == REG_FIFO);
   assign push     = fifo_acc && dp_write && !tx_full;
   assign ovf_evt  = fifo_acc && dp_write && tx_full;
   assign pop      = fifo_acc && !dp_write && !rx_empty;
   assign unf_evt  = fifo_acc && !dp_write && rx_empty;
   assign stat_wr  = dp_valid && dp_write && (dp_reg == REG_STAT);
   assign h2a_push = push && !dp_view;
   assign a2h_push = push && dp_view;
   assign h2a_pop  = pop && dp_view;
   assign a2h_pop  = pop && !dp_view;

   always_comb begin
      ahbls_hrdata = '0;
      if (dp_valid && !dp_write) begin
         case (dp_reg)
            REG_FIFO: ahbls_hrdata = rx_empty ? 32'h0 : rx_head;
            REG_STAT: ahbls_hrdata = stat_word;
            default:  ahbls_hrdata = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dp_valid <= 1'b0;
         dp_view  <= 1'b0;
         dp_write <= 1'b0;
         dp_reg   <= '0;
         h2a_wp   <= '0;
         h2a_rp   <= '0;
         a2h_wp   <= '0;
         a2h_rp   <= '0;
         host_unf <= 1'b0;
         host_ovf <= 1'b0;
         host_ien <= 1'b0;
         apu_unf  <= 1'b0;
         apu_ovf  <= 1'b0;
         apu_ien  <= 1'b0;
      end else begin
         dp_valid <= ahbls_hready && ahbls_htrans[1];
         if (ahbls_hready && ahbls_htrans[1]) begin
            dp_view  <= ahbls_haddr[8];
            dp_write <= ahbls_hwrite;
            dp_reg   <= ahbls_haddr[3:2];
         end
         if (h2a_push) h2a_wp <= h2a_wp + 1'b1;
         if (h2a_pop)  h2a_rp <= h2a_rp + 1'b1;
         if (a2h_push) a2h_wp <= a2h_wp + 1'b1;
         if (a2h_pop)  a2h_rp <= a2h_rp + 1'b1;
         // Only one transfer per cycle, so a set and a clear never coincide
         if (!dp_view) begin
            if (unf_evt) host_unf <= 1'b1;
            if (ovf_evt) host_ovf <= 1'b1;
            if (stat_wr) begin
               if (ahbls_hwdata[8]) host_unf <= 1'b0;
               if (ahbls_hwdata[9]) host_ovf <= 1'b0;
               host_ien <= ahbls_hwdata[16];
            end
         end else begin
            if (unf_evt) apu_unf <= 1'b1;
            if (ovf_evt) apu_ovf <= 1'b1;
            if (stat_wr) begin
               if (ahbls_hwdata[8]) apu_unf <= 1'b0;
               if (ahbls_hwdata[9]) apu_ovf <= 1'b0;
               apu_ien <= ahbls_hwdata[16];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && h2a_push) h2a_mem[h2a_wp[AW-1:0]] <= ahbls_hwdata;
      if (rst_n && a2h_push) a2h_mem[a2h_wp[AW-1:0]] <= ahbls_hwdata;
   end

endmodule

`default_nettype wire
